midori_round_ctrl: RTL and testbench

MIDORI_ROUND_CTRL -- requirements
Module: midori_round_ctrl

---
 rtl/midori_round_ctrl.sv | 110 +++++++++++
 tb/tb_midori_round_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/midori_round_ctrl.sv
// Midori round controller: sequences plaintext/key load, the per-round
// threshold-implementation pipeline stages, and the output handshake.
module midori_round_ctrl #(
    parameter int unsigned ROUNDS = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       clear,
    input  logic       out_ready,
    output logic       busy,
    output logic       load_en,
    output logic       round_en,
    output logic [1:0] stage_idx,
    output logic [4:0] round_idx,
    output logic       last_round,
    output logic       out_valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ROUND = 2'd2,
        OUT   = 2'd3
    } state_e;

    localparam logic [1:0] LAST_STAGE = 2'(STAGES - 1);
    localparam logic [4:0] LAST_RND   = 5'(ROUNDS - 1);

    state_e     state_q, state_d;
    logic [1:0] stage_q, stage_d;
    logic [4:0] round_q, round_d;

    // State and counter registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            stage_q <= '0;
            round_q <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            round_q <= round_d;
        end
    end

    // Next-state and counter update; clear overrides everything else.
    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        round_d = round_q;
        if (clear) begin
            state_d = IDLE;
            stage_d = '0;
            round_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    stage_d = '0;
                    round_d = '0;
                    if (start) begin
                        state_d = LOAD;
                    end
                end
                LOAD: begin
                    state_d = ROUND;
                    stage_d = '0;
                    round_d = '0;
                end
                ROUND: begin
                    if (stage_q == LAST_STAGE) begin
                        stage_d = '0;
                        if (round_q == LAST_RND) begin
                            state_d = OUT;
                        end else begin
                            round_d = round_q + 5'd1;
                        end
                    end else begin
                        stage_d = stage_q + 2'd1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        state_d = IDLE;
                        stage_d = '0;
                        round_d = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    stage_d = '0;
                    round_d = '0;
                end
            endcase
        end
    end

    // Outputs decoded purely from registered state and counters.
    always_comb begin
        busy       = (state_q != IDLE);
        load_en    = (state_q == LOAD);
        round_en   = (state_q == ROUND) && (stage_q == LAST_STAGE);
        last_round = (state_q == ROUND) && (round_q == LAST_RND);
        out_valid  = (state_q == OUT);
        stage_idx  = stage_q;
        round_idx  = round_q;
    end

endmodule

// File: tb/tb_midori_round_ctrl.sv
// Directed bench for midori_round_ctrl: default configuration plus a
// ROUNDS=2 / STAGES=1 instance sharing the same clock.
module tb_midori_round_ctrl;

    logic clk;
    logic rst_n;

    logic start_a, clear_a, out_ready_a;
    logic busy_a, load_en_a, round_en_a, last_round_a, out_valid_a;
    logic [1:0] stage_idx_a;
    logic [4:0] round_idx_a;

    logic start_b, clear_b, out_ready_b;
    logic busy_b, load_en_b, round_en_b, last_round_b, out_valid_b;
    logic [1:0] stage_idx_b;
    logic [4:0] round_idx_b;

    int n_checks;
    int n_errors;

    // Packed observation: {busy, load_en, round_en, stage[1:0], round[4:0], last, valid}
    logic [11:0] obs_a, obs_b;
    assign obs_a = {busy_a, load_en_a, round_en_a, stage_idx_a, round_idx_a, last_round_a, out_valid_a};
    assign obs_b = {busy_b, load_en_b, round_en_b, stage_idx_b, round_idx_b, last_round_b, out_valid_b};

    midori_round_ctrl dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start_a),
        .clear      (clear_a),
        .out_ready  (out_ready_a),
        .busy       (busy_a),
        .load_en    (load_en_a),
        .round_en   (round_en_a),
        .stage_idx  (stage_idx_a),
        .round_idx  (round_idx_a),
        .last_round (last_round_a),
        .out_valid  (out_valid_a)
    );

    midori_round_ctrl #(.ROUNDS(2), .STAGES(1)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start_b),
        .clear      (clear_b),
        .out_ready  (out_ready_b),
        .busy       (busy_b),
        .load_en    (load_en_b),
        .round_en   (round_en_b),
        .stage_idx  (stage_idx_b),
        .round_idx  (round_idx_b),
        .last_round (last_round_b),
        .out_valid  (out_valid_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %03h exp %03h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected outputs of the default instance c cycles after start was sampled.
    function automatic logic [11:0] exp_a(input int c);
        logic       b, ld, ren, lst, ov;
        logic [1:0] st;
        logic [4:0] rd;
        b = 1'b1; ld = 1'b0; ren = 1'b0; lst = 1'b0; ov = 1'b0;
        st = 2'd0; rd = 5'd0;
        if (c == 1) begin
            ld = 1'b1;
        end else if (c >= 2 && c <= 65) begin
            st  = 2'((c - 2) % 4);
            rd  = 5'((c - 2) / 4);
            ren = (st == 2'd3);
            lst = (rd == 5'd15);
        end else if (c >= 66) begin
            ov = 1'b1;
            rd = 5'd15;
        end
        return {b, ld, ren, st, rd, lst, ov};
    endfunction

    // One encryption on the default instance. abort_at>0 stops at that cycle
    // via clear (use_rst=0) or a mid-cycle reset pulse (use_rst=1).
    task automatic run_enc(input string tag, input int hold, input int abort_at, input bit use_rst);
        int last_c;
        last_c = (abort_at > 0) ? abort_at : 66 + hold;
        start_a = 1'b1;
        for (int c = 1; c <= last_c; c++) begin
            tick();
            start_a = (c == 20);
            check_eq(tag, obs_a, exp_a(c));
        end
        if (abort_at > 0 && !use_rst) begin
            clear_a = 1'b1;
            tick();
            check_eq({tag, "_clr"}, obs_a, '0);
            clear_a = 1'b0;
        end else if (abort_at > 0) begin
            #2 rst_n = 1'b0;
            #1 check_eq({tag, "_rst_async"}, obs_a, '0);
            tick();
            check_eq({tag, "_rst_hold"}, obs_a, '0);
            rst_n = 1'b1;
            tick();
            check_eq({tag, "_post_rst0"}, obs_a, '0);
            tick();
            check_eq({tag, "_post_rst1"}, obs_a, '0);
        end else begin
            out_ready_a = 1'b1;
            start_a     = 1'b1;
            tick();
            check_eq({tag, "_idle0"}, obs_a, '0);
            out_ready_a = 1'b0;
            start_a     = 1'b0;
            tick();
            check_eq({tag, "_idle1"}, obs_a, '0);
        end
    endtask

    logic [11:0] exp_b_tbl [1:5];

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        start_a = 1'b0; clear_a = 1'b0; out_ready_a = 1'b0;
        start_b = 1'b0; clear_b = 1'b0; out_ready_b = 1'b1;
        exp_b_tbl[1] = 12'hC00;
        exp_b_tbl[2] = 12'hA00;
        exp_b_tbl[3] = 12'hA06;
        exp_b_tbl[4] = 12'h805;
        exp_b_tbl[5] = 12'h000;

        #1;
        check_eq("reset_a", obs_a, '0);
        check_eq("reset_b", obs_b, '0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("idle_a", obs_a, '0);

        run_enc("enc_hold", 10, 0, 1'b0);
        run_enc("enc_clr", 0, 32, 1'b0);
        run_enc("enc_after_clr", 0, 0, 1'b0);
        run_enc("enc_rst", 0, 14, 1'b1);
        run_enc("enc_after_rst", 3, 0, 1'b0);

        start_b = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            start_b = 1'b0;
            check_eq($sformatf("short_c%0d", c), obs_b, exp_b_tbl[c]);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
